mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers: results are computed when an op is
// accepted and committed to HI/LO after a fixed number of Busy cycles.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Mult,
    input  logic        Multu,
    input  logic        Div,
    input  logic        Divu,
    input  logic        Mthi,
    input  logic        Mtlo,
    input  logic        Mfhi,
    input  logic        Mflo,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] Out
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    typedef enum logic [1:0] {
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU
    } op_t;

    state_t             r_state;
    state_t             w_state_nxt;
    op_t                r_op;
    op_t                w_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_load;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_res_hi;
    logic [31:0]        r_res_lo;
    logic               r_b_zero;
    logic [63:0]        w_res;
    logic               w_op_any;
    logic               w_commit;
    logic               w_commit_wr;
    logic signed [31:0] w_a_s;
    logic signed [31:0] w_b_s;

    // Signed 32x32 -> 64 product; operands sign-extended before multiplying.
    function automatic logic [63:0] mul_s(input logic signed [31:0] a,
                                          input logic signed [31:0] b);
        logic signed [63:0] ax;
        logic signed [63:0] bx;
        logic signed [63:0] p;
        ax = 64'(a);
        bx = 64'(b);
        p  = ax * bx;
        return $unsigned(p);
    endfunction

    function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Signed divide via magnitudes, so 0x80000000 / -1 wraps to 0x80000000 with
    // remainder 0. Returns {remainder, quotient}; a zero divisor is replaced by 1
    // because that result is never committed.
    function automatic logic [63:0] div_s(input logic signed [31:0] a,
                                          input logic signed [31:0] b);
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] uq;
        logic [31:0] ur;
        logic [31:0] quo;
        logic [31:0] rem;
        ua = a[31] ? $unsigned(-a) : $unsigned(a);
        ub = b[31] ? $unsigned(-b) : $unsigned(b);
        if (ub == 32'd0) begin
            ub = 32'd1;
        end
        uq  = ua / ub;
        ur  = ua % ub;
        quo = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
        rem = a[31] ? (32'd0 - ur) : ur;
        return {rem, quo};
    endfunction

    function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ub;
        ub = (b == 32'd0) ? 32'd1 : b;
        return {a % ub, a / ub};
    endfunction

    assign w_a_s    = A;
    assign w_b_s    = B;
    assign w_op_any = Mult | Multu | Div | Divu;
    assign Busy     = (r_state == S_BUSY);
    assign Start    = w_op_any & ~Busy;

    always_comb begin
        w_op       = OP_MULT;
        w_res      = 64'd0;
        w_cnt_load = CNT_W'(MULT_CYCLES);
        if (Mult) begin
            w_op  = OP_MULT;
            w_res = mul_s(w_a_s, w_b_s);
        end else if (Multu) begin
            w_op  = OP_MULTU;
            w_res = mul_u(A, B);
        end else if (Div) begin
            w_op       = OP_DIV;
            w_res      = div_s(w_a_s, w_b_s);
            w_cnt_load = CNT_W'(DIV_CYCLES);
        end else if (Divu) begin
            w_op       = OP_DIVU;
            w_res      = div_u(A, B);
            w_cnt_load = CNT_W'(DIV_CYCLES);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_commit    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A divide by zero runs its full timing but leaves HI/LO untouched.
    assign w_commit_wr = w_commit &
                         ~(((r_op == OP_DIV) || (r_op == OP_DIVU)) && r_b_zero);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op     <= OP_MULT;
            r_cnt    <= '0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_b_zero <= 1'b0;
        end else if (Start) begin
            r_op     <= w_op;
            r_cnt    <= w_cnt_load;
            r_res_hi <= w_res[63:32];
            r_res_lo <= w_res[31:0];
            r_b_zero <= (B == 32'd0);
        end else if (Busy) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Mthi/Mtlo and commit are mutually exclusive: moves only land when idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit_wr) begin
            r_hi <= r_res_hi;
            r_lo <= r_res_lo;
        end else if (!Busy) begin
            if (Mthi) begin
                r_hi <= A;
            end
            if (Mtlo) begin
                r_lo <= A;
            end
        end
    end

    always_comb begin
        Out = 32'd0;
        if (Mfhi) begin
            Out = r_hi;
        end else if (Mflo) begin
            Out = r_lo;
        end
    end

endmodule
